vector_wb_regfile: RTL and testbench
====================================

VECTOR_WB_REGFILE -- requirements
Module: vector_wb_regfile

Interface
REQ-001 SHALL have parameter N, default 8: bits per vector lane.
REQ-002 SHALL have parameter R, default 6: lanes per vector register.
REQ-003 SHALL have parameter NREG, default 16: number of vector registers, addressed by 4 bits.
REQ-004 SHALL have ports as listed below; one clock; reset is asynchronous and active-high.
  clk  in  1  system clock.
  reset  in  1  asynchronous active-high reset.
  RegWriteW  in  1  write-back enable from the MEM/WB pipeline register.
  MemtoRegW  in  1  result select: 1 = ReadDataW, 0 = ALUOutputW.
  FlagsWriteW  in  1  flag-register update enable.
  ALUFlagsW  in  2  ALU flags to store.
  VSIFlagW  in  2  vector/scalar/immediate flags to store.
  LDFlagW  in  1  load flag to store.
  WA3W  in  4  destination register address.
  ReadDataW  in  R*N  memory data, packed [R-1:0][N-1:0].
  ALUOutputW  in  R*N  ALU result, packed [R-1:0][N-1:0].
  RA1D, RA2D  in  4 each  decode-stage read addresses.
  RD1D, RD2D  out  R*N each  read data for RA1D and RA2D.
  ResultW  out  R*N  selected write-back value, also used by the forwarding path.
  FlagsQ  out  5  stored flags {LDF, VSI[1:0], ALUF[1:0]}.
  WrCount  out  16  count of committed register writes.

Function
REQ-005 ResultW SHALL equal ReadDataW when MemtoRegW=1 and ALUOutputW otherwise, combinationally.
REQ-006 On posedge clk with RegWriteW=1, register WA3W SHALL load ResultW; all lanes SHALL be written together.
REQ-007 Writes SHALL use posedge clk, because the upstream W-stage register updates on negedge; data is stable for half a cycle before the write.
REQ-008 RD1D and RD2D SHALL be combinational reads of registers RA1D and RA2D.
REQ-009 Write-through bypass: when RegWriteW=1 and RAxD==WA3W, RDxD SHALL return ResultW, not the stored value.
REQ-010 Both read ports SHALL bypass independently; RA1D==RA2D==WA3W SHALL return ResultW on both ports.
REQ-011 On posedge clk with FlagsWriteW=1, FlagsQ SHALL load {LDFlagW, VSIFlagW, ALUFlagsW}; otherwise FlagsQ SHALL hold.
REQ-012 RegWriteW and FlagsWriteW SHALL act independently; both may be set in the same cycle.
REQ-013 WrCount SHALL increment by 1 on each posedge with RegWriteW=1.
REQ-014 WrCount SHALL wrap from 0xFFFF to 0x0000 with no sticky overflow.
REQ-015 No lane-to-lane carries, sign handling or width conversion SHALL occur; data passes bit-exact.
REQ-016 Writes with RegWriteW=0 SHALL leave all registers unchanged, whatever the values of WA3W and the data inputs.

Reset
REQ-017 While reset=1, all registers, FlagsQ and WrCount SHALL be 0, asynchronously.
REQ-018 A write coinciding with reset SHALL be discarded.
REQ-019 While reset=1, RD1D and RD2D SHALL read 0; the bypass path SHALL be suppressed while reset is asserted.
REQ-020 After reset deasserts, the first posedge SHALL perform a normal write.

Structure
REQ-021 A shared package SHALL hold N, R, NREG, the vector type logic [R-1:0][N-1:0], the 5-bit flags struct and the flag field positions.
REQ-022 The storage array with its two bypassed read ports SHALL be one sub-module, vreg_array.
REQ-023 The ResultW mux, the flags register and WrCount SHALL reside in the top module.

Verification
REQ-024 Reset, then read every address -> RD1D=RD2D=0, FlagsQ=0, WrCount=0.
REQ-025 RegWriteW=1, MemtoRegW=0, WA3W=3, ALUOutputW=0x060504030201; RA1D=3 in the same cycle -> RD1D=0x060504030201 before the edge (bypass) and after it (stored); WrCount=1.
REQ-026 MemtoRegW=1, ReadDataW=0xAABBCCDDEEFF, ALUOutputW=0x111111111111, WA3W=7 -> register 7 = 0xAABBCCDDEEFF.
REQ-027 FlagsWriteW=1, ALUFlagsW=2'b10, VSIFlagW=2'b01, LDFlagW=1, RegWriteW=0 -> FlagsQ=5'b10110; no register changes; WrCount unchanged.
REQ-028 Preload WrCount to 0xFFFF through 65535 writes, then one more write -> WrCount=0x0000.
REQ-029 Assert reset mid-cycle while RegWriteW=1, WA3W=5 -> register 5 stays 0; all outputs read 0 immediately.

Source files
------------

// File: rtl/vector_wb_regfile_pkg.sv
// Shared types and sizes for the vector write-back register file.
package vector_wb_regfile_pkg;

   localparam int VEC_N    = 8;
   localparam int VEC_R    = 6;
   localparam int VEC_NREG = 16;
   localparam int VEC_AW   = 4;

   typedef logic [VEC_R-1:0][VEC_N-1:0] vec_t;

   // Flag word layout, MSB first: {ldf, vsi[1:0], aluf[1:0]}.
   localparam int FLAG_ALUF_LSB = 0;
   localparam int FLAG_VSI_LSB  = 2;
   localparam int FLAG_LDF      = 4;
   localparam int FLAG_W        = 5;

   typedef struct packed {
      logic       ldf;
      logic [1:0] vsi;
      logic [1:0] aluf;
   } flags_t;

endpackage

// File: rtl/vreg_array.sv
// Vector register storage with one write port and two bypassed read ports.
module vreg_array
   import vector_wb_regfile_pkg::*;
#(
   parameter int N    = VEC_N,
   parameter int R    = VEC_R,
   parameter int NREG = VEC_NREG
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    we,
   input  logic [VEC_AW-1:0]       wa,
   input  logic [R-1:0][N-1:0]     wd,
   input  logic [VEC_AW-1:0]       ra1,
   input  logic [VEC_AW-1:0]       ra2,
   output logic [R-1:0][N-1:0]     rd1,
   output logic [R-1:0][N-1:0]     rd2
);

   logic [R-1:0][N-1:0] regs [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   // Write-through: a read of the address being written returns the incoming data.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (!reset) begin
         rd1 = (we && (ra1 == wa)) ? wd : regs[ra1];
         rd2 = (we && (ra2 == wa)) ? wd : regs[ra2];
      end
   end

endmodule

// File: rtl/vector_wb_regfile.sv
// Write-back stage: result select, vector register file, flag register and write counter.
module vector_wb_regfile
   import vector_wb_regfile_pkg::*;
#(
   parameter int N    = VEC_N,
   parameter int R    = VEC_R,
   parameter int NREG = VEC_NREG
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    RegWriteW,
   input  logic                    MemtoRegW,
   input  logic                    FlagsWriteW,
   input  logic [1:0]              ALUFlagsW,
   input  logic [1:0]              VSIFlagW,
   input  logic                    LDFlagW,
   input  logic [VEC_AW-1:0]       WA3W,
   input  logic [R-1:0][N-1:0]     ReadDataW,
   input  logic [R-1:0][N-1:0]     ALUOutputW,
   input  logic [VEC_AW-1:0]       RA1D,
   input  logic [VEC_AW-1:0]       RA2D,
   output logic [R-1:0][N-1:0]     RD1D,
   output logic [R-1:0][N-1:0]     RD2D,
   output logic [R-1:0][N-1:0]     ResultW,
   output logic [FLAG_W-1:0]       FlagsQ,
   output logic [15:0]             WrCount
);

   flags_t flags_q;

   assign ResultW = MemtoRegW ? ReadDataW : ALUOutputW;

   vreg_array #(
      .N    (N),
      .R    (R),
      .NREG (NREG)
   ) u_vreg_array (
      .clk   (clk),
      .reset (reset),
      .we    (RegWriteW),
      .wa    (WA3W),
      .wd    (ResultW),
      .ra1   (RA1D),
      .ra2   (RA2D),
      .rd1   (RD1D),
      .rd2   (RD2D)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
      end else if (FlagsWriteW) begin
         flags_q.ldf  <= LDFlagW;
         flags_q.vsi  <= VSIFlagW;
         flags_q.aluf <= ALUFlagsW;
      end
   end

   assign FlagsQ = flags_q;

   // Free-running modulo-2^16 count of committed writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         WrCount <= '0;
      end else if (RegWriteW) begin
         WrCount <= WrCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_vector_wb_regfile.sv
// Scoreboard bench for vector_wb_regfile: stimulus queues expectations, a monitor compares.
module tb_vector_wb_regfile;
   import vector_wb_regfile_pkg::*;

   logic        clk;
   logic        reset;
   logic        RegWriteW;
   logic        MemtoRegW;
   logic        FlagsWriteW;
   logic [1:0]  ALUFlagsW;
   logic [1:0]  VSIFlagW;
   logic        LDFlagW;
   logic [3:0]  WA3W;
   vec_t        ReadDataW;
   vec_t        ALUOutputW;
   logic [3:0]  RA1D;
   logic [3:0]  RA2D;
   vec_t        RD1D;
   vec_t        RD2D;
   vec_t        ResultW;
   logic [4:0]  FlagsQ;
   logic [15:0] WrCount;

   typedef struct {
      string       nm;
      logic [47:0] rd1;
      logic [47:0] rd2;
      logic [47:0] res;
      logic [4:0]  flags;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   event exp_ev;
   int   checks = 0;
   int   errors = 0;

   vector_wb_regfile #(
      .N    (8),
      .R    (6),
      .NREG (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .RegWriteW   (RegWriteW),
      .MemtoRegW   (MemtoRegW),
      .FlagsWriteW (FlagsWriteW),
      .ALUFlagsW   (ALUFlagsW),
      .VSIFlagW    (VSIFlagW),
      .LDFlagW     (LDFlagW),
      .WA3W        (WA3W),
      .ReadDataW   (ReadDataW),
      .ALUOutputW  (ALUOutputW),
      .RA1D        (RA1D),
      .RA2D        (RA2D),
      .RD1D        (RD1D),
      .RD2D        (RD2D),
      .ResultW     (ResultW),
      .FlagsQ      (FlagsQ),
      .WrCount     (WrCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_now(input string nm, input logic [47:0] rd1, input logic [47:0] rd2,
                             input logic [47:0] res, input logic [4:0] flags, input logic [15:0] cnt);
      exp_t e;
      e.nm = nm; e.rd1 = rd1; e.rd2 = rd2; e.res = res; e.flags = flags; e.cnt = cnt;
      exp_q.push_back(e);
      -> exp_ev;
   endtask

   // Monitor: compares the DUT outputs each time an expectation is presented.
   initial begin
      exp_t e;
      forever begin
         @(exp_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (RD1D !== e.rd1) begin
               errors++;
               $display("FAIL %s rd1: got %h want %h", e.nm, RD1D, e.rd1);
            end
            checks++;
            if (RD2D !== e.rd2) begin
               errors++;
               $display("FAIL %s rd2: got %h want %h", e.nm, RD2D, e.rd2);
            end
            checks++;
            if (ResultW !== e.res) begin
               errors++;
               $display("FAIL %s result: got %h want %h", e.nm, ResultW, e.res);
            end
            checks++;
            if (FlagsQ !== e.flags) begin
               errors++;
               $display("FAIL %s flags: got %b want %b", e.nm, FlagsQ, e.flags);
            end
            checks++;
            if (WrCount !== e.cnt) begin
               errors++;
               $display("FAIL %s wrcount: got %h want %h", e.nm, WrCount, e.cnt);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b0; FlagsWriteW = 1'b0;
      ALUFlagsW = '0; VSIFlagW = '0; LDFlagW = 1'b0; WA3W = '0;
      ReadDataW = '0; ALUOutputW = '0; RA1D = '0; RA2D = '0;

      // Reset state: every address reads zero, during and after reset.
      @(negedge clk); #1;
      expect_now("in_reset", 48'h0, 48'h0, 48'h0, 5'b0, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         RA1D = 4'(a); RA2D = 4'(15 - a);
         #1;
         expect_now("reset_read", 48'h0, 48'h0, 48'h0, 5'b0, 16'h0);
      end

      // ALU write to r3 with same-cycle read: bypass, then stored.
      @(negedge clk);
      RegWriteW = 1'b1; MemtoRegW = 1'b0; WA3W = 4'd3;
      ALUOutputW = 48'h060504030201; RA1D = 4'd3; RA2D = 4'd0;
      #1;
      expect_now("r3_bypass", 48'h060504030201, 48'h0, 48'h060504030201, 5'b0, 16'h0);
      @(negedge clk);
      RegWriteW = 1'b0; ALUOutputW = 48'hDEADBEEFCAFE;
      #1;
      expect_now("r3_stored", 48'h060504030201, 48'h0, 48'hDEADBEEFCAFE, 5'b0, 16'h1);

      // Memory write to r7, both ports bypassing the same address.
      @(negedge clk);
      RegWriteW = 1'b1; MemtoRegW = 1'b1; WA3W = 4'd7;
      ReadDataW = 48'hAABBCCDDEEFF; ALUOutputW = 48'h111111111111;
      RA1D = 4'd7; RA2D = 4'd7;
      #1;
      expect_now("r7_dual_bypass", 48'hAABBCCDDEEFF, 48'hAABBCCDDEEFF, 48'hAABBCCDDEEFF, 5'b0, 16'h1);
      @(negedge clk);
      RegWriteW = 1'b0; MemtoRegW = 1'b0; RA2D = 4'd3;
      #1;
      expect_now("r7_stored", 48'hAABBCCDDEEFF, 48'h060504030201, 48'h111111111111, 5'b0, 16'h2);

      // Flags-only update; a disabled write to r7 with other data must not land.
      @(negedge clk);
      FlagsWriteW = 1'b1; ALUFlagsW = 2'b10; VSIFlagW = 2'b01; LDFlagW = 1'b1;
      RegWriteW = 1'b0; WA3W = 4'd7; ALUOutputW = 48'hFFFFFFFFFFFF;
      #1;
      expect_now("flags_pre", 48'hAABBCCDDEEFF, 48'h060504030201, 48'hFFFFFFFFFFFF, 5'b0, 16'h2);
      @(negedge clk);
      FlagsWriteW = 1'b0; ALUFlagsW = 2'b01; VSIFlagW = 2'b10; LDFlagW = 1'b0;
      #1;
      expect_now("flags_set", 48'hAABBCCDDEEFF, 48'h060504030201, 48'hFFFFFFFFFFFF, 5'b10110, 16'h2);
      @(negedge clk); #1;
      expect_now("flags_hold", 48'hAABBCCDDEEFF, 48'h060504030201, 48'hFFFFFFFFFFFF, 5'b10110, 16'h2);

      // Register write and flag write in the same cycle.
      @(negedge clk);
      RegWriteW = 1'b1; FlagsWriteW = 1'b1; WA3W = 4'd1;
      ALUOutputW = 48'h0102A0B0C0FF; RA1D = 4'd1; RA2D = 4'd7;
      @(negedge clk);
      RegWriteW = 1'b0; FlagsWriteW = 1'b0;
      #1;
      expect_now("reg_and_flags", 48'h0102A0B0C0FF, 48'hAABBCCDDEEFF, 48'h0102A0B0C0FF, 5'b01001, 16'h3);

      // Run WrCount up to 0xFFFF, then one more write wraps it to zero.
      @(negedge clk);
      RegWriteW = 1'b1; WA3W = 4'd2; ALUOutputW = 48'h0000000000AB; RA1D = 4'd2; RA2D = 4'd3;
      repeat (65532) @(posedge clk);
      @(negedge clk); #1;
      expect_now("cnt_ffff", 48'h0000000000AB, 48'h060504030201, 48'h0000000000AB, 5'b01001, 16'hFFFF);
      @(negedge clk);
      RegWriteW = 1'b0;
      #1;
      expect_now("cnt_wrap", 48'h0000000000AB, 48'h060504030201, 48'h0000000000AB, 5'b01001, 16'h0000);

      // Reset asserted mid-cycle during a pending write to r5.
      @(negedge clk);
      RegWriteW = 1'b1; WA3W = 4'd5; ALUOutputW = 48'h555555555555; RA1D = 4'd5; RA2D = 4'd7;
      #1;
      expect_now("r5_bypass", 48'h555555555555, 48'hAABBCCDDEEFF, 48'h555555555555, 5'b01001, 16'h0);
      #1;
      reset = 1'b1;
      #1;
      expect_now("reset_async", 48'h0, 48'h0, 48'h555555555555, 5'b0, 16'h0);
      @(posedge clk); #1;
      expect_now("reset_edge", 48'h0, 48'h0, 48'h555555555555, 5'b0, 16'h0);
      @(negedge clk);
      reset = 1'b0; RegWriteW = 1'b0;
      #1;
      expect_now("r5_discarded", 48'h0, 48'h0, 48'h555555555555, 5'b0, 16'h0);

      // First edge after reset performs a normal write.
      @(negedge clk);
      RegWriteW = 1'b1; ALUOutputW = 48'h123456789ABC;
      @(negedge clk);
      RegWriteW = 1'b0;
      #1;
      expect_now("post_reset_write", 48'h123456789ABC, 48'h0, 48'h123456789ABC, 5'b0, 16'h1);

      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
